rf_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port register file. It shares that port between the SPI-side interface (requester 0) and the waveform sequencer's parameter fetch (requester 1). It serialises their accesses, drives the register-file strobes, returns read data with a one-cycle acknowledge, and flags out-of-range addresses. It sits between the SPI interface, the sequencer and the register file, in the system clock domain.

---
 rtl/rf_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rf_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_arbiter.sv
// rf_arbiter: two-requester arbiter and sequencer for the single-port
// register file. Requester 0 is the SPI-side interface, requester 1 is the
// waveform sequencer's parameter fetch. Each granted access runs through
// IDLE -> ISSUE -> (RDWAIT) -> DONE and ends with a one-cycle ack to its owner.
//
// Optional feature macro: RF_ARB_RR_EN
//   defined   -> round-robin arbitration on ties (pointer resets to "last = 1")
//   undefined -> fixed priority, requester 0 always wins ties
`timescale 1ns/1ps

module rf_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 32
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              rf_re_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic [DATA_W-1:0] rf_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One extra bit so an RF_DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(RF_DEPTH);

  state_t state;

  // Command register: the parts of the granted request still needed after
  // ISSUE. Address and write data live in rf_addr_o/rf_wdata_o, which are
  // loaded at grant so the strobe cycle already sees them.
  logic owner;
  logic cmd_we;
  logic cmd_err;

  logic              grant_valid;
  logic              grant_sel;
  logic              sel_we;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef RF_ARB_RR_EN
  logic last_grant;

  // Round-robin winner selection: on a tie, the requester not granted last wins.
  always_comb begin
    grant_valid = req0_i | req1_i;
    grant_sel   = 1'b0;
    if (req0_i && req1_i) begin
      grant_sel = ~last_grant;
    end else if (req1_i) begin
      grant_sel = 1'b1;
    end
  end
`else
  // Fixed-priority winner selection: requester 0 wins every tie.
  always_comb begin
    grant_valid = req0_i | req1_i;
    grant_sel   = ~req0_i;
  end
`endif

  // Mux the winning requester's command and range-check its address.
  always_comb begin
    sel_we    = grant_sel ? we1_i    : we0_i;
    sel_addr  = grant_sel ? addr1_i  : addr0_i;
    sel_wdata = grant_sel ? wdata1_i : wdata0_i;
    sel_err   = ({1'b0, sel_addr} >= DEPTH_EXT);
  end

  // Sequencer FSM with all outputs registered; strobes and acks default low
  // so each is a single-cycle pulse.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_err    <= 1'b0;
      ack0_o     <= 1'b0;
      ack1_o     <= 1'b0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
      rf_re_o    <= 1'b0;
      rf_we_o    <= 1'b0;
      rdata_o    <= '0;
      rf_addr_o  <= '0;
      rf_wdata_o <= '0;
`ifdef RF_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack0_o  <= 1'b0;
      ack1_o  <= 1'b0;
      err_o   <= 1'b0;
      rf_re_o <= 1'b0;
      rf_we_o <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            state   <= ISSUE;
            busy_o  <= 1'b1;
            owner   <= grant_sel;
            cmd_we  <= sel_we;
            cmd_err <= sel_err;
            if (!sel_err) begin
              rf_addr_o  <= sel_addr;
              rf_wdata_o <= sel_wdata;
              rf_we_o    <= sel_we;
              rf_re_o    <= ~sel_we;
            end
`ifdef RF_ARB_RR_EN
            last_grant <= grant_sel;
`endif
          end
        end

        ISSUE: begin
          if (cmd_err || cmd_we) begin
            state  <= DONE;
            ack0_o <= ~owner;
            ack1_o <= owner;
            err_o  <= cmd_err;
            if (cmd_err && !cmd_we) begin
              rdata_o <= '0;
            end
          end else begin
            state <= RDWAIT;
          end
        end

        RDWAIT: begin
          state   <= DONE;
          rdata_o <= rf_rdata_i;
          ack0_o  <= ~owner;
          ack1_o  <= owner;
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter: directed self-checking bench for rf_arbiter.
// A small register-file model answers rf_re_o one cycle later. Inputs are
// driven and outputs sampled on the falling clock edge.
// Optional feature macro: RF_ARB_RR_EN selects the round-robin tie expectations.
`timescale 1ns/1ps

module tb_rf_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, err, busy, rf_re, rf_we;
  logic [15:0] rdata, rf_wdata, rf_rdata;
  logic [7:0]  rf_addr;

  logic [15:0] mem [32];

  int total  = 0;
  int passed = 0;

  int owners [4];
  int ack_at [4];
  int n_acks;
  int both_cnt;
  int ack1_cnt;
  int stray_acks;

  rf_arbiter #(.ADDR_W(8), .DATA_W(16), .RF_DEPTH(32)) dut (
    .sys_clk_i (sys_clk),
    .sys_rst_i (sys_rst),
    .req0_i    (req0),
    .req1_i    (req1),
    .we0_i     (we0),
    .we1_i     (we1),
    .addr0_i   (addr0),
    .addr1_i   (addr1),
    .wdata0_i  (wdata0),
    .wdata1_i  (wdata1),
    .ack0_o    (ack0),
    .ack1_o    (ack1),
    .err_o     (err),
    .rdata_o   (rdata),
    .busy_o    (busy),
    .rf_re_o   (rf_re),
    .rf_we_o   (rf_we),
    .rf_addr_o (rf_addr),
    .rf_wdata_o(rf_wdata),
    .rf_rdata_i(rf_rdata)
  );

  // Free-running system clock, 10 ns period.
  always #5 sys_clk = ~sys_clk;

  // Register-file model: synchronous write, read data the cycle after rf_re.
  always @(posedge sys_clk) begin
    if (rf_we) mem[rf_addr[4:0]] <= rf_wdata;
    if (rf_re) rf_rdata <= mem[rf_addr[4:0]];
  end

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic applyStimulus(input int who, input logic req, input logic we,
                               input logic [7:0] addr, input logic [15:0] wdata);
    if (who == 0) begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Reset state
    step(); step();
    checkOutput("rst_ack0", ack0, 0);
    checkOutput("rst_ack1", ack1, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_re", rf_re, 0);
    checkOutput("rst_we", rf_we, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_addr", rf_addr, 0);
    checkOutput("rst_wdata", rf_wdata, 0);
    sys_rst = 1'b1;
    step();
    checkOutput("idle_busy", busy, 0);

    // Requester 0 writes 0xBEEF to 0x05
    $display("[TB] write 0x05 <= 0xBEEF from requester 0");
    applyStimulus(0, 1'b1, 1'b1, 8'h05, 16'hBEEF);
    step();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("wr_we", rf_we, 1);
    checkOutput("wr_re", rf_re, 0);
    checkOutput("wr_addr", rf_addr, 32'h05);
    checkOutput("wr_wdata", rf_wdata, 32'hBEEF);
    checkOutput("wr_busy", busy, 1);
    checkOutput("wr_ack_early", ack0, 0);
    step();
    checkOutput("wr_ack0", ack0, 1);
    checkOutput("wr_ack1", ack1, 0);
    checkOutput("wr_err", err, 0);
    checkOutput("wr_we_off", rf_we, 0);
    step();
    checkOutput("wr_ack_gone", ack0, 0);
    checkOutput("wr_busy_idle", busy, 0);

    // Requester 0 reads 0x05 back
    $display("[TB] read 0x05 from requester 0");
    applyStimulus(0, 1'b1, 1'b0, 8'h05, 16'h0000);
    step();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("rd_re", rf_re, 1);
    checkOutput("rd_we", rf_we, 0);
    step();
    checkOutput("rd_ack_wait", ack0, 0);
    checkOutput("rd_re_off", rf_re, 0);
    step();
    checkOutput("rd_ack0", ack0, 1);
    checkOutput("rd_rdata", rdata, 32'hBEEF);
    checkOutput("rd_err", err, 0);
    step();
    checkOutput("rd_ack_gone", ack0, 0);

    // Requester 1 reads out-of-range address 0x20
    $display("[TB] error read 0x20 from requester 1");
    applyStimulus(1, 1'b1, 1'b0, 8'h20, 16'h0000);
    step();
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("err_re", rf_re, 0);
    checkOutput("err_we", rf_we, 0);
    checkOutput("err_busy", busy, 1);
    step();
    checkOutput("err_ack1", ack1, 1);
    checkOutput("err_flag", err, 1);
    checkOutput("err_ack0", ack0, 0);
    checkOutput("err_rdata", rdata, 0);
    step();
    checkOutput("err_flag_gone", err, 0);
    checkOutput("err_busy_idle", busy, 0);

    // Requester 1 write withdrawn in ISSUE with a changed address
    $display("[TB] withdrawn write 0x0A <= 0x1234 from requester 1");
    applyStimulus(1, 1'b1, 1'b1, 8'h0A, 16'h1234);
    step();
    applyStimulus(1, 1'b0, 1'b1, 8'h07, 16'hDEAD);
    checkOutput("wd_we", rf_we, 1);
    checkOutput("wd_addr", rf_addr, 32'h0A);
    checkOutput("wd_wdata", rf_wdata, 32'h1234);
    step();
    checkOutput("wd_ack1", ack1, 1);
    checkOutput("wd_addr_hold", rf_addr, 32'h0A);
    step();
    applyStimulus(0, 1'b1, 1'b0, 8'h0A, 16'h0000);
    step();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(); step();
    checkOutput("wd_rb_ack0", ack0, 1);
    checkOutput("wd_rb_rdata", rdata, 32'h1234);
    step();

    // Both requesters held from reset
    $display("[TB] tie with both requests held from reset");
    sys_rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 8'h01, 16'h1111);
    applyStimulus(1, 1'b1, 1'b1, 8'h02, 16'h2222);
    step();
    checkOutput("tie_rst_busy", busy, 0);
    sys_rst = 1'b1;
    n_acks = 0; both_cnt = 0; ack1_cnt = 0;
    for (int i = 0; i < 4; i++) owners[i] = -1;
    for (int c = 0; c < 40 && n_acks < 4; c++) begin
      step();
      if (ack0 && ack1) both_cnt++;
      if (ack1) ack1_cnt++;
      if (ack0 || ack1) begin
        owners[n_acks] = ack1 ? 1 : 0;
        n_acks++;
      end
    end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(); step();
    checkOutput("tie_acks", n_acks, 4);
    checkOutput("tie_both", both_cnt, 0);
    for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_RR_EN
      checkOutput($sformatf("tie_owner%0d", i), owners[i], i % 2);
`else
      checkOutput($sformatf("tie_owner%0d", i), owners[i], 0);
`endif
    end
`ifndef RF_ARB_RR_EN
    checkOutput("tie_ack1_count", ack1_cnt, 0);
`endif
    checkOutput("tie_busy_idle", busy, 0);

    // Reset asserted during RDWAIT
    $display("[TB] reset during RDWAIT");
    applyStimulus(0, 1'b1, 1'b0, 8'h05, 16'h0000);
    step();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    step();
    checkOutput("rw_busy", busy, 1);
    #1 sys_rst = 1'b0;
    #1;
    checkOutput("rw_rst_busy", busy, 0);
    checkOutput("rw_rst_re", rf_re, 0);
    checkOutput("rw_rst_we", rf_we, 0);
    checkOutput("rw_rst_ack0", ack0, 0);
    step();
    sys_rst = 1'b1;
    stray_acks = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ack0 || ack1) stray_acks++;
    end
    checkOutput("rw_no_ack", stray_acks, 0);
    applyStimulus(0, 1'b1, 1'b0, 8'h0A, 16'h0000);
    step();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("rw_new_re", rf_re, 1);
    step(); step();
    checkOutput("rw_new_ack0", ack0, 1);
    checkOutput("rw_new_rdata", rdata, 32'h1234);
    step();

    // Back-to-back writes with requester 0 holding req
    $display("[TB] back-to-back writes from requester 0");
    for (int i = 0; i < 4; i++) ack_at[i] = 0;
    n_acks = 0;
    applyStimulus(0, 1'b1, 1'b1, 8'h10, 16'hA5A5);
    for (int s = 1; s <= 12; s++) begin
      step();
      if (s == 7) applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      if (ack0) begin
        if (n_acks < 4) ack_at[n_acks] = s;
        n_acks++;
      end
    end
    checkOutput("b2b_count", n_acks, 3);
    checkOutput("b2b_first", ack_at[0], 2);
    checkOutput("b2b_gap1", ack_at[1] - ack_at[0], 3);
    checkOutput("b2b_gap2", ack_at[2] - ack_at[1], 3);
    checkOutput("b2b_mem", mem[16], 32'hA5A5);
    checkOutput("b2b_busy_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
